// File: rtl/timer_ctrl_pkg.sv
// Shared constants for timer_ctrl: register map, CTRL bit positions and
// the per-channel sequencing state codes.
package timer_ctrl_pkg;

  localparam logic [2:0] ADDR_VALUE0  = 3'd0;
  localparam logic [2:0] ADDR_CTRL0   = 3'd3;
  localparam logic [2:0] ADDR_PENDING = 3'd6;
  localparam logic [2:0] ADDR_ENABLE  = 3'd7;

  localparam int CTRL_START    = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_STOP     = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_ARM      = 3'd2,
    ST_RUN      = 3'd3,
    ST_CXL_LOAD = 3'd4,
    ST_CXL_WAIT = 3'd5
  } chan_state_e;

endpackage

// File: rtl/timer_ctrl_chan.sv
// One timer channel: VALUE register, periodic latch and the FSM that drives
// the OStimer load/trigger handshake, including cancel by forced expiry.
module timer_ctrl_chan
  import timer_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        value_we,
  input  logic [31:0] value_wdata,
  input  logic        ctrl_we,
  input  logic [2:0]  ctrl_wdata,
  input  logic        tmr_irq,
  output logic [31:0] value,
  output logic [2:0]  state_code,
  output logic        periodic,
  output logic [31:0] tmr_value,
  output logic        tmr_set,
  output logic        tmr_trigger,
  output logic        pend_set
);

  chan_state_e state;
  logic        start;
  logic        stop;

  assign start      = ctrl_we && ctrl_wdata[CTRL_START];
  assign stop       = ctrl_we && ctrl_wdata[CTRL_STOP];
  assign state_code = state;
  assign pend_set   = tmr_irq && (state == ST_RUN);
  // Loading zero makes the timer expire at once, which is how a cancel is done.
  assign tmr_value  = (state == ST_CXL_LOAD) ? 32'd0 : value;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      value       <= 32'd0;
      periodic    <= 1'b0;
      tmr_set     <= 1'b0;
      tmr_trigger <= 1'b0;
    end else begin
      if (value_we)
        value <= value_wdata;
      tmr_set     <= 1'b0;
      tmr_trigger <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            periodic <= ctrl_wdata[CTRL_PERIODIC];
            tmr_set  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (stop) begin
            state <= ST_IDLE;
          end else begin
            state       <= ST_ARM;
            tmr_trigger <= 1'b1;
          end
        end
        ST_ARM: begin
          if (stop) begin
            state    <= ST_CXL_LOAD;
            periodic <= 1'b0;
            tmr_set  <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // An expiry in the same cycle as STOP is reported but never reloaded.
          if (tmr_irq) begin
            if (periodic && !stop) begin
              state   <= ST_LOAD;
              tmr_set <= 1'b1;
            end else begin
              state <= ST_IDLE;
              if (stop)
                periodic <= 1'b0;
            end
          end else if (stop) begin
            state    <= ST_CXL_LOAD;
            periodic <= 1'b0;
            tmr_set  <= 1'b1;
          end
        end
        ST_CXL_LOAD: state <= ST_CXL_WAIT;
        ST_CXL_WAIT: begin
          if (tmr_irq)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Memory-mapped front end for NCH OStimer channels: bus decode, W1C pending
// register, interrupt enable and the merged level interrupt.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int NCH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        bus_addr,
  input  logic [31:0]       bus_data,
  input  logic              bus_we,
  input  logic              bus_start,
  output logic              bus_done,
  output logic [31:0]       bus_q,
  output logic [NCH*32-1:0] tmr_value,
  output logic [NCH-1:0]    tmr_set,
  output logic [NCH-1:0]    tmr_trigger,
  input  logic [NCH-1:0]    tmr_irq,
  output logic              irq
);

  logic           wr;
  logic [NCH-1:0] pend_set;
  logic [NCH-1:0] pend_clr;
  logic [NCH-1:0] pending, pending_nxt;
  logic [NCH-1:0] enable, enable_nxt;
  logic [NCH-1:0] chan_periodic;
  logic [31:0]    chan_value [NCH];
  logic [2:0]     chan_state [NCH];
  logic [31:0]    rdata;

  assign wr = bus_start && bus_we;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    timer_ctrl_chan u_chan (
      .clk         (clk),
      .reset       (reset),
      .value_we    (wr && (bus_addr == ADDR_VALUE0 + 3'(c))),
      .value_wdata (bus_data),
      .ctrl_we     (wr && (bus_addr == ADDR_CTRL0 + 3'(c))),
      .ctrl_wdata  (bus_data[2:0]),
      .tmr_irq     (tmr_irq[c]),
      .value       (chan_value[c]),
      .state_code  (chan_state[c]),
      .periodic    (chan_periodic[c]),
      .tmr_value   (tmr_value[32*c +: 32]),
      .tmr_set     (tmr_set[c]),
      .tmr_trigger (tmr_trigger[c]),
      .pend_set    (pend_set[c])
    );
  end

  // Hardware set is OR-ed in after the clear so it wins a same-cycle W1C.
  assign pend_clr    = (wr && bus_addr == ADDR_PENDING) ? bus_data[NCH-1:0] : '0;
  assign pending_nxt = (pending & ~pend_clr) | pend_set;
  assign enable_nxt  = (wr && bus_addr == ADDR_ENABLE) ? bus_data[NCH-1:0] : enable;

  always_comb begin
    rdata = 32'd0;
    for (int c = 0; c < NCH; c++) begin
      if (bus_addr == ADDR_VALUE0 + 3'(c))
        rdata = chan_value[c];
      if (bus_addr == ADDR_CTRL0 + 3'(c))
        rdata = {28'd0, chan_periodic[c], chan_state[c]};
    end
    if (bus_addr == ADDR_PENDING)
      rdata = 32'(pending);
    if (bus_addr == ADDR_ENABLE)
      rdata = 32'(enable);
  end

  // irq is computed from the next-state values so it tracks PENDING/ENABLE
  // in the same cycle they change.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      enable   <= '0;
      irq      <= 1'b0;
      bus_done <= 1'b0;
      bus_q    <= 32'd0;
    end else begin
      pending  <= pending_nxt;
      enable   <= enable_nxt;
      irq      <= |(pending_nxt & enable_nxt);
      bus_done <= bus_start;
      bus_q    <= (bus_start && !bus_we) ? rdata : 32'd0;
    end
  end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Memory-mapped controller that sequences three `OStimer` one-shot millisecond timers on behalf of the CPU. It owns each timer's load/trigger handshake, adds periodic auto-reload and cancel, and merges the three timer pulses into one maskable, level-sensitive interrupt with a write-1-to-clear pending register. It sits between the memory unit's IO bus and the timer instances.

## Interface
- `NCH`, 3: number of timer channels; the register map below is fixed for 3.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; also drives the timers' `reset`.
- `bus_addr` in 3: register select.
- `bus_data` in 32: write data.
- `bus_we` in 1: 1 = write, 0 = read; valid with `bus_start`.
- `bus_start` in 1: one-cycle access request.
- `bus_done` out 1: one-cycle completion pulse.
- `bus_q` out 32: read data, valid while `bus_done`=1, else 0.
- `tmr_value` out 3×32: per-channel `timerValue`, channel c at bits [32c+31:32c].
- `tmr_set` out 3: per-channel `setValue` pulse.
- `tmr_trigger` out 3: per-channel `trigger` pulse.
- `tmr_irq` in 3: per-channel timer `interrupt` (one-cycle pulse).
- `irq` out 1: `|(pending & enable)`, registered.

## Operation
- Register map: 0–2 VALUE[c] (R/W, 32b); 3–5 CTRL[c] (W: bit0 START, bit1 PERIODIC, bit2 STOP; R: bits[2:0] = channel state code, bit3 = periodic latch); 6 PENDING (R; W1C on bits[2:0]); 7 ENABLE (R/W bits[2:0]). Unused read bits = 0.
- Per-channel FSM, states IDLE(0), LOAD(1), ARM(2), RUN(3), CXL_LOAD(4), CXL_WAIT(5).
- IDLE: START write → LOAD; PERIODIC bit latched at that write. STOP ignored.
- LOAD: drive `tmr_value`=VALUE[c], `tmr_set`=1 for one cycle → ARM.
- ARM: `tmr_trigger`=1 for one cycle → RUN.
- RUN: `tmr_irq`=1 → set PENDING[c]; periodic latch=1 → LOAD, else → IDLE.
- STOP in LOAD → IDLE (timer never triggered). STOP in ARM or RUN → CXL_LOAD; periodic latch cleared.
- CXL_LOAD: drive `tmr_value`=0, `tmr_set`=1 one cycle (forces expiry) → CXL_WAIT.
- CXL_WAIT: `tmr_irq`=1 swallowed (PENDING untouched) → IDLE.
- START while not IDLE: ignored. `tmr_irq` outside RUN/CXL_WAIT: ignored.
- VALUE writes at any time; take effect at the next LOAD, so periodic period changes apply from the next reload.
- `tmr_value` = VALUE[c] except during CXL_LOAD; `tmr_set`/`tmr_trigger` = 0 outside their states.

## Timing
- Reset: all FSMs IDLE; VALUE, PENDING, ENABLE, periodic latches = 0; `bus_done`, `bus_q`, `tmr_set`, `tmr_trigger`, `irq` = 0; `tmr_value` = 0.
- Bus: `bus_start` at cycle T → `bus_done`=1 and `bus_q` at T+1; write side effects visible from T+1. No back-pressure; `bus_start` at T+1 is legal.
- START written at T: LOAD at T+1, ARM at T+2, RUN at T+3.
- Reload: `tmr_irq` at T → PENDING[c] and `irq` at T+1, `tmr_set` at T+1, `tmr_trigger` at T+2. Never drive `tmr_set` in the cycle `tmr_irq` is high (the timer's set would override its done→idle step).
- Simultaneous `tmr_irq` and STOP in RUN: the interrupt wins (PENDING set); the channel goes IDLE with no reload.
- Simultaneous hardware set and W1C on the same PENDING bit: the set wins.
- Channels are independent; multiple PENDING bits may set in the same cycle.

## Structure
- Shared package/header: register address constants, CTRL bit positions, FSM state codes.
- One sub-module: `timer_ctrl_chan` (per-channel FSM, VALUE register, periodic latch), instantiated NCH times. The top holds the bus decode, PENDING, ENABLE and `irq`.

## Test plan
- Reset mid-RUN on ch0 → all outputs 0, CTRL[0] read = 0, `irq`=0.
- VALUE[0]=2, ENABLE=1, START ch0 → `tmr_set`+value 2, then `tmr_trigger`; on timer pulse PENDING=001, `irq`=1; W1C 1 → `irq`=0 next cycle.
- VALUE[1]=1, START|PERIODIC ch1 → `tmr_irq` re-armed (`tmr_set` at T+1, `tmr_trigger` at T+2) for 3 periods; STOP → `tmr_value`=0 set pulse, next pulse swallowed, CTRL[1] reads IDLE.
- `tmr_irq`[2] and W1C bit2 in the same cycle → PENDING[2] stays 1.
- ENABLE=000 with expiry on ch0 → PENDING=001, `irq`=0; ENABLE=001 → `irq`=1 next cycle.
- START on a running channel, and STOP on an idle channel → no `tmr_set`/`tmr_trigger` pulses and no state change.
